// File: rtl/change_dispenser.sv
// ============================================================================
//  Module      : change_dispenser
//  Description : Payout engine for change/refunds. Accepts a rupee amount and
//                issues coins greedily (Rs2 first, then Rs1) to two hoppers,
//                one coin at a time, each held until the hopper acknowledges.
//                Keeps the on-board coin inventory and reports the amount
//                paid together with shortfall / fault status.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, reset              clock, synchronous active-high reset
//    req_valid/req_ready     payout request handshake (ready only in IDLE)
//    req_amount              rupees to pay out
//    load_en/load_one/two    inventory replace strobe (honoured in IDLE)
//    coin_one_out/two_out    hopper drive, held until hopper_ack
//    hopper_ack              hopper released the driven coin
//    done                    one-cycle end-of-transaction pulse
//    paid/short/fault        result of last transaction
//    inv_one/inv_two         current coin inventory
//
//  Build option
//    DISP_ACK_TIMEOUT_EN     when defined, a coin not acknowledged within
//                            ACK_TIMEOUT cycles aborts the transaction with
//                            fault=1; otherwise ISSUE waits indefinitely.
// ============================================================================
`default_nettype none

module change_dispenser #(
    parameter int AMT_W       = 4,
    parameter int INV_W       = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load_en,
    input  logic [INV_W-1:0] load_one,
    input  logic [INV_W-1:0] load_two,
    output logic             coin_one_out,
    output logic             coin_two_out,
    input  logic             hopper_ack,
    output logic             done,
    output logic [AMT_W-1:0] paid,
    output logic             short,
    output logic             fault,
    output logic [INV_W-1:0] inv_one,
    output logic [INV_W-1:0] inv_two
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ISSUE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AMT_W-1:0] c_AMT_ONE  = AMT_W'(1);
    localparam logic [AMT_W-1:0] c_AMT_TWO  = AMT_W'(2);
    localparam logic [INV_W-1:0] c_INV_ONE  = INV_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [AMT_W-1:0]   r_remaining;
    logic [AMT_W-1:0]   r_paid;
    logic               r_short;
    logic [INV_W-1:0]   r_inv_one;
    logic [INV_W-1:0]   r_inv_two;
    logic               r_sel_two;
    logic [GAP_W-1:0]   r_gap_cnt;
    // Holds req_ready low for the first cycle out of reset.
    logic               r_live;

    logic               w_accept;
    logic               w_load;
    logic               w_pick_two;
    logic               w_pick_one;
    logic               w_ack_take;
    logic               w_timeout;
    logic [AMT_W-1:0]   w_coin_val;

    assign w_accept   = req_valid && req_ready;
    assign w_load     = (r_state == S_IDLE) && load_en;
    assign w_pick_two = (r_remaining >= c_AMT_TWO) && (r_inv_two != '0);
    assign w_pick_one = (r_remaining != '0) && (r_inv_one != '0);
    assign w_ack_take = (r_state == S_ISSUE) && hopper_ack;
    assign w_coin_val = r_sel_two ? c_AMT_TWO : c_AMT_ONE;

`ifdef DISP_ACK_TIMEOUT_EN
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_fault;

    // Cycles spent in ISSUE for the current coin; an ack on the last
    // allowed cycle still wins over the timeout.
    assign w_timeout = (r_state == S_ISSUE) && !hopper_ack && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_accept) begin
                r_fault <= 1'b0;
            end else if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign fault = r_fault;
`else
    assign w_timeout = 1'b0;
    assign fault     = 1'b0;

    // Timeout length only matters when the timeout build is selected.
    if (ACK_TIMEOUT < 1) begin : g_ack_timeout_unused
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_remaining == '0) begin
                    w_next_state = S_DONE;
                end else if (w_pick_two || w_pick_one) begin
                    w_next_state = S_ISSUE;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_ISSUE: begin
                if (hopper_ack) begin
                    w_next_state = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
                end else if (w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_next_state = S_SELECT;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_remaining <= '0;
            r_paid      <= '0;
            r_short     <= 1'b0;
            r_inv_one   <= '0;
            r_inv_two   <= '0;
            r_sel_two   <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_live  <= 1'b1;

            // Load and accept may coincide; SELECT runs a cycle later and
            // therefore already sees the freshly loaded counts.
            if (w_load) begin
                r_inv_one <= load_one;
                r_inv_two <= load_two;
            end

            if (w_accept) begin
                r_remaining <= req_amount;
                r_paid      <= '0;
                r_short     <= 1'b0;
            end

            if (r_state == S_SELECT) begin
                r_sel_two <= w_pick_two;
                // Remaining 1 with only Rs2 coins is a shortfall: never overpay.
                if ((r_remaining != '0) && !w_pick_two && !w_pick_one) begin
                    r_short <= 1'b1;
                end
            end

            if (w_ack_take) begin
                r_remaining <= r_remaining - w_coin_val;
                r_paid      <= r_paid + w_coin_val;
                if (r_sel_two) begin
                    r_inv_two <= r_inv_two - c_INV_ONE;
                end else begin
                    r_inv_one <= r_inv_one - c_INV_ONE;
                end
            end

            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE) && r_live;
    assign coin_two_out = (r_state == S_ISSUE) && r_sel_two;
    assign coin_one_out = (r_state == S_ISSUE) && !r_sel_two;
    assign done         = (r_state == S_DONE);
    assign paid         = r_paid;
    assign short        = r_short;
    assign inv_one      = r_inv_one;
    assign inv_two      = r_inv_two;

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout-side counterpart of the coin-accept FSM: returns change or a refund by driving ₹2 and ₹1 coin hoppers.
- Accepts a payout request for an amount in rupees. Issues coins greedily, one at a time, with a valid/ack handshake to the hopper.
- Tracks on-board coin inventory.
- Reports completion, amount actually paid, and shortfall or fault status to the sale controller.

Parameters:
AMT_W, 4, width of requested/paid amount in rupees (max request 2^AMT_W-1)
INV_W, 8, width of each coin inventory counter
GAP_CYCLES, 2, idle cycles enforced between successive coins (0 allowed)
ACK_TIMEOUT, 16, cycles to wait for hopper_ack before fault (used only with DISP_ACK_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  payout request present
req_amount  input  AMT_W  rupees to pay out
req_ready  output  1  high only in IDLE; request accepted when req_valid&&req_ready
load_en  input  1  inventory load strobe (honoured only in IDLE)
load_one  input  INV_W  new ₹1 coin count
load_two  input  INV_W  new ₹2 coin count
coin_one_out  output  1  drive ₹1 hopper; held until acked
coin_two_out  output  1  drive ₹2 hopper; held until acked
hopper_ack  input  1  hopper has released the currently driven coin
done  output  1  one-cycle pulse at end of transaction
paid  output  AMT_W  rupees paid in last transaction, valid from done until next accept
short  output  1  last transaction ended with remaining>0 due to inventory; valid with paid
fault  output  1  last transaction aborted by ack timeout; valid with paid
inv_one  output  INV_W  current ₹1 inventory
inv_two  output  INV_W  current ₹2 inventory

Behaviour:
- Reset: state IDLE; all outputs 0 (req_ready goes 1 the cycle after reset deasserts); remaining=0; inventories 0. Reset mid-transaction aborts immediately: no done pulse, coin outputs drop the same cycle.
- States: IDLE, SELECT, ISSUE, GAP, DONE.
- IDLE: req_ready=1.
  - load_en: inv_one<=load_one, inv_two<=load_two (replace, not add).
  - Accept: remaining<=req_amount, paid<=0, short<=0, fault<=0, go to SELECT.
  - load_en and accept in the same cycle: the load applies first, so selection uses the new counts.
  - load_en outside IDLE is ignored.
- SELECT, one cycle, priority order:
  - remaining==0 -> DONE.
  - remaining>=2 && inv_two>0 -> ISSUE(two).
  - remaining>=1 && inv_one>0 -> ISSUE(one).
  - Otherwise short<=1 -> DONE.
  - Never overpay: remaining==1 with inv_one==0 is short even if inv_two>0.
- ISSUE:
  - Exactly one of coin_one_out/coin_two_out is high for the whole state.
  - hopper_ack sampled high: remaining -= value, paid += value, matching inventory -= 1, then go to GAP, or to SELECT if GAP_CYCLES==0.
  - Coin output deasserts the cycle after ack.
  - hopper_ack while not in ISSUE is ignored.
- GAP: counts GAP_CYCLES cycles with both coin outputs low, then SELECT.
- DONE: done=1 for one cycle, then IDLE. paid/short/fault hold until the next accept.
- Request latency: accept at cycle N -> SELECT at N+1 -> first coin output at N+2.
- Zero-amount request: done at N+2, paid=0, short=0.
- Arithmetic: paid never exceeds req_amount; inventories never underflow (guarded by SELECT).
- Invariant: paid + remaining == req_amount throughout the transaction.

Optional Feature:
- Macro DISP_ACK_TIMEOUT_EN.
- Defined: a counter starts on ISSUE entry. If hopper_ack is not seen within ACK_TIMEOUT cycles, the coin output drops, fault<=1, and the FSM goes to DONE. The coin is not counted and inventory is unchanged.
- Undefined: ISSUE waits indefinitely for hopper_ack; fault is tied 0.

Test Plan:
- Load inv_one=5, inv_two=5; request 5, ack 1 cycle after each coin -> coins two,two,one; done with paid=5, short=0; inv_one=4, inv_two=3; coins separated by 2 idle cycles.
- Load inv_one=0, inv_two=3; request 3 -> one ₹2 coin, then done with paid=2, short=1; inv_two=2.
- Request 0 from IDLE at cycle N -> done at N+2, paid=0, no coin output ever asserted.
- Request 4, hold hopper_ack low 10 cycles on the first coin -> coin_two_out stays high 10 cycles; paid advances only after ack; final paid=4.
- Reset asserted while coin_two_out high -> next cycle all outputs 0, IDLE, inventories 0, no done.
- With DISP_ACK_TIMEOUT_EN, ACK_TIMEOUT=16: request 2, never ack -> coin_two_out drops after 16 cycles; done with fault=1, paid=0; inv_two unchanged.
